mips_cpu_bus_bridge: RTL and testbench

Parametrised bridge between the combinational Harvard port pair of the MIPS core (instruction fetch, data access) and a single shared Avalon-style memory bus with `waitrequest`. The bridge sequences every instruction as fetch → decode → optional data access → commit, holding the fetched word stable while the core decodes it. It drives the core's clock enable so the core advances exactly one instruction per commit. Added over the previous generation: bus stall tolerance, width parameters, a stall timeout with a sticky error flag, and a retired-instruction counter.

---
 rtl/mips_cpu_bus_pkg.sv | 19 +
 rtl/mips_cpu_bus_timer.sv | 32 +++
 rtl/mips_cpu_bus_bridge.sv | 146 ++++++++++++++
 tb/tb_mips_cpu_bus_bridge.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// rtl/mips_cpu_bus_pkg.sv - shared state encoding and bus geometry helpers for the MIPS bus bridge
package mips_cpu_bus_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    MEM,
    COMMIT,
    HALT
  } state_t;

  // Shifted left by log2(lanes) and truncated to ADDR_W to form the word-alignment mask.
  localparam logic [63:0] ALIGN_ONES = '1;

  function automatic int byte_lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mips_cpu_bus_timer.sv
// rtl/mips_cpu_bus_timer.sv - consecutive wait-cycle counter; expired flags the LIMIT-th stalled cycle
module mips_cpu_bus_timer #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic incr,
  output logic expired
);

  generate
    if (LIMIT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
      logic [CW-1:0] count;

      always_ff @(posedge clk) begin
        if (!reset || clear) begin
          count <= '0;
        end else if (incr) begin
          count <= count + 1'b1;
        end
      end

      // The current stalled cycle is the LIMIT-th one when LIMIT-1 have already been counted.
      assign expired = incr && (count == CW'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/mips_cpu_bus_bridge.sv
// rtl/mips_cpu_bus_bridge.sv - sequences MIPS fetch/decode/mem/commit over one waitrequest-style bus
module mips_cpu_bus_bridge
  import mips_cpu_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int COUNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   core_active,
  output logic                   core_clk_enable,
  input  logic [ADDR_W-1:0]      core_instr_address,
  output logic [DATA_W-1:0]      core_instr_readdata,
  input  logic [ADDR_W-1:0]      core_data_address,
  input  logic                   core_data_read,
  input  logic                   core_data_write,
  input  logic [DATA_W/8-1:0]    core_data_byteenable,
  input  logic [DATA_W-1:0]      core_data_writedata,
  output logic [DATA_W-1:0]      core_data_readdata,
  output logic [ADDR_W-1:0]      bus_address,
  output logic                   bus_read,
  output logic                   bus_write,
  output logic [DATA_W/8-1:0]    bus_byteenable,
  output logic [DATA_W-1:0]      bus_writedata,
  input  logic                   bus_waitrequest,
  input  logic [DATA_W-1:0]      bus_readdata,
  output logic                   bus_error,
  output logic [COUNT_W-1:0]     instr_count
);

  localparam int LANES = byte_lanes(DATA_W);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(ALIGN_ONES << $clog2(LANES));

  state_t state, state_next;

  logic [DATA_W-1:0]   instr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic [COUNT_W-1:0]  count_q;

  logic                rd, wr, clk_en;
  logic [ADDR_W-1:0]   addr;
  logic [LANES-1:0]    be;
  logic [DATA_W-1:0]   wd;
  logic                timer_clear, expired;
  logic                capture_instr, capture_data, fail;

  mips_cpu_bus_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .incr    ((rd || wr) && bus_waitrequest),
    .expired (expired)
  );

  // Strobes and address come from state and core requests only; waitrequest steers next state.
  always_comb begin
    state_next    = state;
    rd            = 1'b0;
    wr            = 1'b0;
    addr          = '0;
    be            = '0;
    wd            = '0;
    clk_en        = 1'b0;
    timer_clear   = 1'b1;
    capture_instr = 1'b0;
    capture_data  = 1'b0;
    fail          = 1'b0;
    case (state)
      FETCH: begin
        if (!core_active) begin
          state_next = HALT;
        end else begin
          rd          = 1'b1;
          addr        = core_instr_address & ADDR_MASK;
          be          = '1;
          timer_clear = 1'b0;
          if (expired) begin
            fail       = 1'b1;
            state_next = HALT;
          end else if (!bus_waitrequest) begin
            capture_instr = 1'b1;
            state_next    = DECODE;
          end
        end
      end
      DECODE: begin
        state_next = (core_data_read || core_data_write) ? MEM : COMMIT;
      end
      MEM: begin
        wr          = core_data_write;
        rd          = core_data_read && !core_data_write;
        addr        = core_data_address & ADDR_MASK;
        be          = core_data_byteenable;
        wd          = core_data_write ? core_data_writedata : '0;
        timer_clear = 1'b0;
        if (expired) begin
          fail       = 1'b1;
          state_next = HALT;
        end else if (!bus_waitrequest) begin
          capture_data = rd;
          state_next   = COMMIT;
        end
      end
      COMMIT: begin
        clk_en     = 1'b1;
        state_next = FETCH;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH;
      instr_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state <= state_next;
      if (capture_instr) instr_q <= bus_readdata;
      if (capture_data)  rdata_q <= bus_readdata;
      if (fail)          err_q   <= 1'b1;
      if (clk_en)        count_q <= count_q + 1'b1;
    end
  end

  assign core_clk_enable     = reset && clk_en;
  assign core_instr_readdata = reset ? instr_q : '0;
  assign core_data_readdata  = reset ? rdata_q : '0;
  assign bus_address         = reset ? addr : '0;
  assign bus_read            = reset && rd;
  assign bus_write           = reset && wr;
  assign bus_byteenable      = reset ? be : '0;
  assign bus_writedata       = reset ? wd : '0;
  assign bus_error           = reset && err_q;
  assign instr_count         = reset ? count_q : '0;

endmodule

// File: tb/tb_mips_cpu_bus_bridge.sv
// tb/tb_mips_cpu_bus_bridge.sv - randomized self-checking bench for mips_cpu_bus_bridge
module tb_mips_cpu_bus_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_active;
  logic        core_clk_enable;
  logic [31:0] core_instr_address;
  logic [31:0] core_instr_readdata;
  logic [31:0] core_data_address;
  logic        core_data_read;
  logic        core_data_write;
  logic [3:0]  core_data_byteenable;
  logic [31:0] core_data_writedata;
  logic [31:0] core_data_readdata;
  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic        bus_waitrequest;
  logic [31:0] bus_readdata;
  logic        bus_error;
  logic [3:0]  instr_count;

  int errors = 0;
  int checks = 0;

  int unsigned model_count;
  logic [31:0] last_load;
  logic [31:0] pc;

  mips_cpu_bus_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TMO),
    .COUNT_W (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .core_active          (core_active),
    .core_clk_enable      (core_clk_enable),
    .core_instr_address   (core_instr_address),
    .core_instr_readdata  (core_instr_readdata),
    .core_data_address    (core_data_address),
    .core_data_read       (core_data_read),
    .core_data_write      (core_data_write),
    .core_data_byteenable (core_data_byteenable),
    .core_data_writedata  (core_data_writedata),
    .core_data_readdata   (core_data_readdata),
    .bus_address          (bus_address),
    .bus_read             (bus_read),
    .bus_write            (bus_write),
    .bus_byteenable       (bus_byteenable),
    .bus_writedata        (bus_writedata),
    .bus_waitrequest      (bus_waitrequest),
    .bus_readdata         (bus_readdata),
    .bus_error            (bus_error),
    .instr_count          (instr_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset                = 1'b0;
    core_active          = 1'b1;
    core_instr_address   = $urandom;
    core_data_address    = $urandom;
    core_data_read       = 1'b1;
    core_data_write      = 1'b1;
    core_data_byteenable = 4'hF;
    core_data_writedata  = $urandom;
    bus_waitrequest      = 1'b0;
    bus_readdata         = $urandom;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_strobes", {bus_read, bus_write, core_clk_enable, bus_error}, 0);
      check("rst_bus", {bus_address, bus_writedata, bus_byteenable}, 0);
      check("rst_core", {core_instr_readdata, core_data_readdata}, 0);
      check("rst_count", instr_count, 0);
      next_cycle();
    end
    reset       = 1'b1;
    model_count = 0;
    last_load   = '0;
  endtask

  // kind: 0 alu, 1 load, 2 store, 3 read+write (write wins). fw/mw: slave wait cycles.
  task automatic run_instr(input int kind, input int fw, input int mw,
                           input logic [31:0] daddr, input logic [3:0] be,
                           input logic [31:0] rword, output bit halted);
    logic [31:0] iword, wdata;
    bit mem, is_rd, is_wr, err, ferr;
    int t_fa, fe, t_dec, t_ms, me, t_commit, t_err, last;
    iword = $urandom;
    wdata = $urandom;
    mem   = (kind != 0);
    is_rd = (kind == 1);
    is_wr = (kind == 2) || (kind == 3);
    core_active          = 1'b1;
    core_instr_address   = pc;
    core_data_address    = daddr;
    core_data_byteenable = be;
    core_data_writedata  = wdata;
    core_data_read       = (kind == 1) || (kind == 3);
    core_data_write      = is_wr;

    ferr  = (fw >= TMO);
    err   = ferr;
    t_err = TMO;
    t_fa  = 1 + fw;
    fe    = ferr ? TMO : t_fa;
    t_dec = t_fa + 1;
    t_ms  = t_dec + 1;
    me    = t_ms + mw;
    if (!ferr && mem && mw >= TMO) begin
      err   = 1'b1;
      t_err = t_ms + TMO - 1;
      me    = t_err;
    end
    t_commit = mem ? t_ms + mw + 1 : t_dec + 1;
    last     = err ? t_err + 3 : t_commit;

    for (int c = 1; c <= last; c++) begin
      bit in_f, in_m, exp_rd, exp_wr, exp_ce;
      in_f   = (c <= fe);
      in_m   = !ferr && mem && (c >= t_ms) && (c <= me);
      exp_rd = in_f || (in_m && !is_wr);
      exp_wr = in_m && is_wr;
      exp_ce = !err && (c == t_commit);
      if (in_f) begin
        bus_waitrequest = (c - 1) < fw;
        bus_readdata    = iword;
      end else if (in_m) begin
        bus_waitrequest = (c - t_ms) < mw;
        bus_readdata    = rword;
      end else begin
        bus_waitrequest = $urandom_range(0, 1);
        bus_readdata    = $urandom;
      end
      @(negedge clk);
      check("bus_read", bus_read, exp_rd);
      check("bus_write", bus_write, exp_wr);
      check("clk_enable", core_clk_enable, exp_ce);
      if (in_f) begin
        check("fetch_addr", bus_address, pc & 32'hFFFF_FFFC);
        check("fetch_be", bus_byteenable, 4'hF);
      end
      if (in_m) begin
        check("mem_addr", bus_address, daddr & 32'hFFFF_FFFC);
        check("mem_be", bus_byteenable, be);
        if (is_wr) check("mem_wdata", bus_writedata, wdata);
      end
      if (!ferr && c == t_dec) check("decode_instr", core_instr_readdata, iword);
      if (exp_ce) begin
        check("commit_instr", core_instr_readdata, iword);
        check("commit_load", core_data_readdata, is_rd ? rword : last_load);
        check("commit_count", instr_count, model_count);
        check("commit_error", bus_error, 0);
      end
      if (err && c > t_err) begin
        check("timeout_error", bus_error, 1);
        check("timeout_count", instr_count, model_count);
      end
      next_cycle();
    end

    halted = err;
    if (!err) begin
      model_count = (model_count + 1) % 16;
      if (is_rd) last_load = rword;
      pc = $urandom;
    end
  endtask

  task automatic run_halt();
    core_active = 1'b0;
    @(negedge clk);
    check("halt_read", bus_read, 0);
    next_cycle();
    core_active = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_waitrequest = 1'b0;
      @(negedge clk);
      check("halt_strobes", {bus_read, bus_write, core_clk_enable}, 0);
      check("halt_count", instr_count, model_count);
      next_cycle();
    end
  endtask

  task automatic reset_mid_load();
    core_active          = 1'b1;
    core_instr_address   = pc;
    core_data_address    = 32'h0000_3000;
    core_data_read       = 1'b1;
    core_data_write      = 1'b0;
    core_data_byteenable = 4'hF;
    bus_readdata         = $urandom;
    bus_waitrequest      = 1'b0;
    next_cycle();
    next_cycle();
    bus_waitrequest = 1'b1;
    @(negedge clk);
    check("rml_read", bus_read, 1);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("rml_strobes", {bus_read, bus_write, core_clk_enable, bus_error}, 0);
    check("rml_outs", {bus_address, bus_byteenable, instr_count, core_instr_readdata}, 0);
    next_cycle();
    reset           = 1'b1;
    bus_waitrequest = 1'b1;
    model_count     = 0;
    last_load       = '0;
    @(negedge clk);
    check("rml_refetch", bus_read, 1);
    check("rml_addr", bus_address, pc & 32'hFFFF_FFFC);
    check("rml_count", instr_count, 0);
    check("rml_instr", core_instr_readdata, 0);
    next_cycle();
  endtask

  initial begin
    bit h;
    pc = 32'h0000_0100;
    do_reset();

    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 32'h0, 4'h0, 32'h0, h);
    run_halt();
    do_reset();

    run_instr(1, 0, 2, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, h);
    run_instr(2, 0, 0, 32'h0000_2003, 4'b1000, 32'h0, h);
    run_instr(3, 1, 1, 32'h0000_2104, 4'b0011, 32'h0, h);
    run_instr(1, TMO - 1, TMO - 1, 32'h0000_4000, 4'hF, $urandom, h);
    run_instr(0, TMO, 0, 32'h0, 4'h0, 32'h0, h);
    do_reset();
    run_instr(1, 0, TMO, 32'h0000_5000, 4'hF, $urandom, h);
    do_reset();

    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 32'h0, 4'h0, 32'h0, h);
    reset_mid_load();
    do_reset();

    for (int i = 0; i < 17; i++) run_instr(0, 0, 0, 32'h0, 4'h0, 32'h0, h);
    @(negedge clk);
    check("wrap17", instr_count, 1);
    next_cycle();
    do_reset();

    for (int i = 0; i < 200; i++) begin
      int kind, fw, mw;
      kind = $urandom_range(0, 3);
      fw   = ($urandom_range(0, 9) < 9) ? $urandom_range(0, TMO - 1) : TMO;
      mw   = ($urandom_range(0, 9) < 9) ? $urandom_range(0, TMO - 1) : TMO + 1;
      run_instr(kind, fw, mw, $urandom, 4'($urandom_range(0, 15)), $urandom, h);
      if (h) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
